// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: instruction-memory port, control inputs and the IF/ID register outputs.
// The master modport is the fetch unit; the slave modport is the surrounding pipeline/memory.
interface instruction_fetch_if #(
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 16
);
    logic               start;
    logic               stall;
    logic               branch_en;
    logic [ADDR_W-1:0]  branch_target;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_instr;
    logic               if_valid;
    logic [INSTR_W-1:0] if_instr;
    logic [ADDR_W-1:0]  if_pc;
    logic               halted;

    modport master (
        input  start,
        input  stall,
        input  branch_en,
        input  branch_target,
        output imem_addr,
        input  imem_instr,
        output if_valid,
        output if_instr,
        output if_pc,
        output halted
    );

    modport slave (
        output start,
        output stall,
        output branch_en,
        output branch_target,
        input  imem_addr,
        output imem_instr,
        input  if_valid,
        input  if_instr,
        input  if_pc,
        input  halted
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, combinational imem addressing, IF/ID register, stall/branch/halt control.
// Optional IF_PERF_CNT_EN adds a saturating 16-bit count of valid fetches (perf_fetch_cnt).
module instruction_fetch #(
    parameter int                ADDR_W   = 4,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
`ifdef IF_PERF_CNT_EN
    output logic [15:0]                perf_fetch_cnt,
`endif
    instruction_fetch_if.master        bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_pc;
    logic [ADDR_W-1:0]  w_pc_nxt;
    logic               r_if_valid;
    logic               w_if_valid_nxt;
    logic [INSTR_W-1:0] r_if_instr;
    logic [INSTR_W-1:0] w_if_instr_nxt;
    logic [ADDR_W-1:0]  r_if_pc;
    logic [ADDR_W-1:0]  w_if_pc_nxt;
    logic               w_fetch_load;
    logic               w_halt_word;

    assign w_halt_word = (bus.imem_instr == '0);

    // NOTE: every output of this block gets a hold default first, so no path leaves a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_if_valid_nxt = r_if_valid;
        w_if_instr_nxt = r_if_instr;
        w_if_pc_nxt    = r_if_pc;
        w_fetch_load   = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_if_valid_nxt = 1'b0;
                if (bus.start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // Branch outranks stall: the wrong-path word is dropped even under back-pressure.
                if (bus.branch_en) begin
                    w_pc_nxt       = bus.branch_target;
                    w_if_valid_nxt = 1'b0;
                end else if (bus.stall) begin
                    w_pc_nxt = r_pc;
                end else if (w_halt_word) begin
                    w_if_valid_nxt = 1'b0;
                    w_state_nxt    = S_HALT;
                end else begin
                    w_if_instr_nxt = bus.imem_instr;
                    w_if_pc_nxt    = r_pc;
                    w_if_valid_nxt = 1'b1;
                    w_pc_nxt       = r_pc + 1'b1;
                    w_fetch_load   = 1'b1;
                end
            end
            S_HALT: begin
                w_if_valid_nxt = 1'b0;
            end
            default: begin
                w_state_nxt    = S_IDLE;
                w_if_valid_nxt = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_pc       <= RESET_PC;
            r_if_valid <= 1'b0;
            r_if_instr <= '0;
            r_if_pc    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_if_valid <= w_if_valid_nxt;
            r_if_instr <= w_if_instr_nxt;
            r_if_pc    <= w_if_pc_nxt;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [15:0] r_perf_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_cnt <= '0;
        end else if (w_fetch_load && (r_perf_cnt != 16'hFFFF)) begin
            r_perf_cnt <= r_perf_cnt + 16'd1;
        end
    end

    assign perf_fetch_cnt = r_perf_cnt;
`endif

    assign bus.imem_addr = r_pc;
    assign bus.if_valid  = r_if_valid;
    assign bus.if_instr  = r_if_instr;
    assign bus.if_pc     = r_if_pc;
    assign bus.halted    = (r_state == S_HALT);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: sequential fetch, halt, stall, branch, wrap, reset.
// Build with IF_PERF_CNT_EN defined to also check the fetch counter.
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] mem [16];
    int          n_vec = 0;
    int          n_err = 0;
`ifdef IF_PERF_CNT_EN
    logic [15:0] perf_fetch_cnt;
`endif

    instruction_fetch_if #(.ADDR_W(4), .INSTR_W(16)) bus ();

    instruction_fetch #(.ADDR_W(4), .INSTR_W(16), .RESET_PC(4'h0)) dut (
        .clk            (clk),
        .rst            (rst),
`ifdef IF_PERF_CNT_EN
        .perf_fetch_cnt (perf_fetch_cnt),
`endif
        .bus            (bus.master)
    );

    // Combinational instruction memory model.
    assign bus.imem_instr = mem[bus.imem_addr];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock edge, then settle before the bench samples or drives.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_perf(input string tag, input logic [15:0] exp);
`ifdef IF_PERF_CNT_EN
        check(tag, {16'h0, perf_fetch_cnt}, {16'h0, exp});
`endif
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus.stall = 1'b0;
        bus.branch_en = 1'b0;
        bus.branch_target = 4'h0;
        step();
        rst = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    initial begin
        logic [15:0] prog [9];
        prog = '{16'h0012, 16'h1032, 16'h0014, 16'h1012, 16'h34CB,
                 16'h5010, 16'h5012, 16'h34CB, 16'h0000};
        for (int i = 0; i < 16; i++) mem[i] = 16'hFFFF;
        for (int i = 0; i < 9; i++) mem[i] = prog[i];

        // Reset values
        do_reset();
        check("rst_valid",  {31'h0, bus.if_valid}, 32'h0);
        check("rst_halted", {31'h0, bus.halted},   32'h0);
        check("rst_pc",     {28'h0, bus.imem_addr}, 32'h0);
        check("rst_instr",  {16'h0, bus.if_instr},  32'h0);
        check("rst_if_pc",  {28'h0, bus.if_pc},     32'h0);
        check_perf("rst_perf", 16'd0);

        // IDLE holds without start
        step();
        check("idle_valid", {31'h0, bus.if_valid}, 32'h0);
        check("idle_pc",    {28'h0, bus.imem_addr}, 32'h0);

        // Straight-line program up to the halt word
        do_start();
        check("start_valid", {31'h0, bus.if_valid}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("seq_instr%0d", i), {16'h0, bus.if_instr}, {16'h0, prog[i]});
            check($sformatf("seq_pc%0d", i), {28'h0, bus.if_pc}, i);
            check($sformatf("seq_valid%0d", i), {31'h0, bus.if_valid}, 32'h1);
        end
        step();
        check("halt_halted", {31'h0, bus.halted},    32'h1);
        check("halt_valid",  {31'h0, bus.if_valid},  32'h0);
        check("halt_pc",     {28'h0, bus.imem_addr}, 32'h8);
        check_perf("halt_perf", 16'd8);

        // Branch and start are ignored in HALT
        bus.branch_en = 1'b1;
        bus.branch_target = 4'h3;
        bus.start = 1'b1;
        step();
        bus.branch_en = 1'b0;
        bus.start = 1'b0;
        check("halt_hold_halted", {31'h0, bus.halted},    32'h1);
        check("halt_hold_pc",     {28'h0, bus.imem_addr}, 32'h8);

        // Reset out of HALT
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rsth_halted", {31'h0, bus.halted},    32'h0);
        check("rsth_pc",     {28'h0, bus.imem_addr}, 32'h0);
        check("rsth_valid",  {31'h0, bus.if_valid},  32'h0);
        check_perf("rsth_perf", 16'd0);

        // Stall for three cycles after word 1 is captured
        do_start();
        step();
        step();
        check("pre_stall_pc", {28'h0, bus.if_pc}, 32'h1);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("stall_instr%0d", i), {16'h0, bus.if_instr}, {16'h0, prog[1]});
            check($sformatf("stall_ifpc%0d", i), {28'h0, bus.if_pc}, 32'h1);
            check($sformatf("stall_pc%0d", i), {28'h0, bus.imem_addr}, 32'h2);
        end
        bus.stall = 1'b0;
        step();
        check("post_stall_pc0", {28'h0, bus.if_pc},    32'h2);
        check("post_stall_in0", {16'h0, bus.if_instr}, {16'h0, prog[2]});
        check("post_stall_v0",  {31'h0, bus.if_valid}, 32'h1);
        check_perf("post_stall_perf", 16'd3);

        // Start while already running has no effect; pc is 3 here
        bus.start = 1'b1;
        check("run_pc3", {28'h0, bus.imem_addr}, 32'h3);
        // Branch to 6 while pc == 3: one bubble
        bus.branch_en = 1'b1;
        bus.branch_target = 4'h6;
        step();
        bus.branch_en = 1'b0;
        bus.start = 1'b0;
        check("br_valid",  {31'h0, bus.if_valid},  32'h0);
        check("br_pc",     {28'h0, bus.imem_addr}, 32'h6);
        check("br_ifpc",   {28'h0, bus.if_pc},     32'h2);
        step();
        check("br_t_valid", {31'h0, bus.if_valid}, 32'h1);
        check("br_t_ifpc",  {28'h0, bus.if_pc},    32'h6);
        check("br_t_instr", {16'h0, bus.if_instr}, 32'h5012);
        check_perf("br_perf", 16'd4);

        // Branch together with stall: branch wins
        bus.branch_en = 1'b1;
        bus.stall = 1'b1;
        bus.branch_target = 4'h2;
        step();
        bus.branch_en = 1'b0;
        check("brst_pc",    {28'h0, bus.imem_addr}, 32'h2);
        check("brst_valid", {31'h0, bus.if_valid},  32'h0);
        step();
        check("brst_hold_pc", {28'h0, bus.imem_addr}, 32'h2);
        check("brst_hold_v",  {31'h0, bus.if_valid},  32'h0);
        bus.stall = 1'b0;
        step();
        check("brst_t_ifpc",  {28'h0, bus.if_pc},    32'h2);
        check("brst_t_instr", {16'h0, bus.if_instr}, 32'h0014);

        // Reset mid-RUN
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstr_valid",  {31'h0, bus.if_valid},  32'h0);
        check("rstr_pc",     {28'h0, bus.imem_addr}, 32'h0);
        check("rstr_halted", {31'h0, bus.halted},    32'h0);
        check_perf("rstr_perf", 16'd0);

        // PC wrap F -> 0 with all words nonzero
        for (int i = 0; i < 16; i++) mem[i] = 16'hA000 | 16'(i);
        do_start();
        bus.branch_en = 1'b1;
        bus.branch_target = 4'hE;
        step();
        bus.branch_en = 1'b0;
        step();
        check("wrap_ifpc_e", {28'h0, bus.if_pc}, 32'hE);
        step();
        check("wrap_ifpc_f", {28'h0, bus.if_pc},     32'hF);
        check("wrap_pc_0",   {28'h0, bus.imem_addr}, 32'h0);
        step();
        check("wrap_ifpc_0",  {28'h0, bus.if_pc},    32'h0);
        check("wrap_instr_0", {16'h0, bus.if_instr}, 32'hA000);
        check("wrap_valid",   {31'h0, bus.if_valid}, 32'h1);
        check_perf("wrap_perf", 16'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
